// File: rtl/arb_pkg.sv
// Shared word width and FSM state encodings for the memory port-2 arbiter.
package arb_pkg;

    localparam int WORD_SIZE = 16;

    typedef enum logic [1:0] {
        S_CPU     = 2'b00,
        S_HANDOFF = 2'b01,
        S_DMA     = 2'b10,
        S_RECLAIM = 2'b11
    } arb_state_t;

endpackage

// File: rtl/arb_stat_counter.sv
// Free-running enable counter that wraps at all-ones; used for DMA write-cycle statistics.
module arb_stat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset_n)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Port-2 arbiter between the CPU load/store stage and the DMAC (BR/BG handshake with turnarounds).
// Optional DMA write-cycle statistics are built when ARB_STAT_EN is defined.
module mem_bus_arbiter
    import arb_pkg::*;
#(
    parameter int WORD_SIZE  = arb_pkg::WORD_SIZE,
    parameter int WAIT_LIMIT = 8,
    parameter int WAIT_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cpu_req,
    input  logic                 cpu_write,
    input  logic                 cpu_lock,
    input  logic [WORD_SIZE-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic                 cpu_stall,
    input  logic                 dma_br,
    output logic                 dma_bg,
    input  logic                 dma_write,
    input  logic [WORD_SIZE-1:0] dma_addr,
    input  logic [WORD_SIZE-1:0] dma_wdata,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic                 bus_err,
    output logic [15:0]          dma_cycles
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_LIMIT[WAIT_W-1:0];

    arb_state_t        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              force_handoff;

    assign force_handoff = (WAIT_LIMIT != 0) && (wait_cnt == LIMIT);

    // dma_bg is assigned alongside the next state so it always equals (state == S_DMA).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= S_CPU;
            wait_cnt <= '0;
            dma_bg   <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            if (dma_write && state != S_DMA)
                bus_err <= 1'b1;
            case (state)
                S_CPU: begin
                    dma_bg <= 1'b0;
                    if (dma_br && (!cpu_lock || force_handoff)) begin
                        state    <= S_HANDOFF;
                        wait_cnt <= '0;
                    end else if (dma_br && cpu_lock) begin
                        wait_cnt <= (wait_cnt == LIMIT) ? wait_cnt : wait_cnt + 1'b1;
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                S_HANDOFF: begin
                    state  <= S_DMA;
                    dma_bg <= 1'b1;
                end
                S_DMA: begin
                    if (!dma_br) begin
                        state  <= S_RECLAIM;
                        dma_bg <= 1'b0;
                    end else begin
                        dma_bg <= 1'b1;
                    end
                end
                default: begin
                    // BR is ignored here so the CPU always gets one cycle between bursts.
                    state  <= S_CPU;
                    dma_bg <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            S_CPU: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_read  = cpu_req & ~cpu_write;
                mem_write = cpu_req & cpu_write;
            end
            S_DMA: begin
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                mem_write = dma_write;
            end
            default: ;
        endcase
    end

    assign cpu_stall = cpu_req && (state != S_CPU);

`ifdef ARB_STAT_EN
    arb_stat_counter #(.W(16)) u_stat (
        .clk     (clk),
        .reset_n (reset_n),
        .en      ((state == S_DMA) && dma_write),
        .count   (dma_cycles)
    );
`else
    assign dma_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: handoff, burst, lock/forced handoff, reclaim, bus error, reset.
module tb_mem_bus_arbiter;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         cpu_req, cpu_write, cpu_lock;
    logic [W-1:0] cpu_addr, cpu_wdata;
    logic         dma_br, dma_write;
    logic [W-1:0] dma_addr, dma_wdata;

    logic         cpu_stall, dma_bg, mem_read, mem_write, bus_err;
    logic [W-1:0] mem_addr, mem_wdata;
    logic [15:0]  dma_cycles;

    logic         cpu_stall0, dma_bg0, mem_read0, mem_write0, bus_err0;
    logic [W-1:0] mem_addr0, mem_wdata0;
    logic [15:0]  dma_cycles0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.WORD_SIZE(W), .WAIT_LIMIT(8), .WAIT_W(4)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_lock(cpu_lock),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall),
        .dma_br(dma_br), .dma_bg(dma_bg), .dma_write(dma_write),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .bus_err(bus_err), .dma_cycles(dma_cycles)
    );

    // Same stimulus, but never forces a handoff while cpu_lock is held.
    mem_bus_arbiter #(.WORD_SIZE(W), .WAIT_LIMIT(0), .WAIT_W(4)) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_lock(cpu_lock),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall0),
        .dma_br(dma_br), .dma_bg(dma_bg0), .dma_write(dma_write),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .mem_read(mem_read0), .mem_write(mem_write0), .mem_addr(mem_addr0),
        .mem_wdata(mem_wdata0), .bus_err(bus_err0), .dma_cycles(dma_cycles0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] exp_cycles;
        reset_n = 1'b0; cpu_req = 1'b0; cpu_write = 1'b0; cpu_lock = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; dma_br = 1'b0; dma_write = 1'b0;
        dma_addr = '0; dma_wdata = '0;
        tick(); tick();

        // Reset state
        chk("rst_bg", dma_bg, 0);
        chk("rst_err", bus_err, 0);
        chk("rst_cycles", dma_cycles, 0);
        chk("rst_stall", cpu_stall, 0);
        reset_n = 1'b1;

        // CPU read served while it owns the port
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 16'h1234; cpu_wdata = 16'h5A5A;
        #1;
        chk("cpu_rd", mem_read, 1);
        chk("cpu_rd_addr", mem_addr, 16'h1234);
        chk("cpu_rd_stall", cpu_stall, 0);

        // Unblocked BR -> HANDOFF (port idle) -> DMA with grant
        dma_br = 1'b1; dma_addr = 16'h01F4; dma_wdata = 16'hA000;
        tick();
        chk("ho_bg", dma_bg, 0);
        chk("ho_rd", mem_read, 0);
        chk("ho_wr", mem_write, 0);
        chk("ho_addr", mem_addr, 0);
        chk("ho_wdata", mem_wdata, 0);
        chk("ho_stall", cpu_stall, 1);
        tick();
        chk("dma_bg", dma_bg, 1);
        chk("dma_addr", mem_addr, 16'h01F4);
        chk("dma_rd", mem_read, 0);

        // 12-word DMA burst while CPU is trying to write: DMA wins
        cpu_write = 1'b1;
        for (int i = 0; i < 12; i++) begin
            dma_write = 1'b1;
            dma_addr  = 16'h01F4 + 16'(i);
            dma_wdata = 16'hA000 + 16'(i);
            #1;
            chk("burst_wr", mem_write, 1);
            chk("burst_addr", mem_addr, 16'h01F4 + 16'(i));
            chk("burst_wdata", mem_wdata, 16'hA000 + 16'(i));
            chk("burst_stall", cpu_stall, 1);
            tick();
        end
        dma_write = 1'b0; dma_br = 1'b0;
`ifdef ARB_STAT_EN
        exp_cycles = 16'd12;
`else
        exp_cycles = 16'd0;
`endif
        chk("burst_cycles", dma_cycles, exp_cycles);
        chk("burst_err", bus_err, 0);
        tick();
        chk("reclaim_bg", dma_bg, 0);
        chk("reclaim_stall", cpu_stall, 1);
        chk("reclaim_wr", mem_write, 0);
        tick();
        chk("back_stall", cpu_stall, 0);
        chk("back_wr", mem_write, 1);
        chk("back_addr", mem_addr, 16'h1234);
        chk("back_wdata", mem_wdata, 16'h5A5A);

        // cpu_lock blocks BR for 8 cycles, 9th cycle is still served, then forced handoff
        cpu_write = 1'b0; cpu_lock = 1'b1; dma_br = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("lock_bg", dma_bg, 0);
            chk("lock_stall", cpu_stall, 0);
        end
        chk("lock_9th_rd", mem_read, 1);
        tick();
        chk("force_ho_stall", cpu_stall, 1);
        chk("force_ho_rd", mem_read, 0);
        tick();
        chk("force_bg", dma_bg, 1);
        chk("nolimit_bg", dma_bg0, 0);
        chk("nolimit_stall", cpu_stall0, 0);

        // Unforced instance hands off only after the lock drops
        cpu_lock = 1'b0;
        tick();
        chk("unlock_ho_stall", cpu_stall0, 1);
        chk("unlock_ho_bg", dma_bg0, 0);
        tick();
        chk("unlock_bg", dma_bg0, 1);

        // BR drops then reasserts: RECLAIM, one served CPU cycle, then HANDOFF
        dma_br = 1'b0;
        tick();
        chk("drop_bg", dma_bg, 0);
        chk("drop_stall", cpu_stall, 1);
        dma_br = 1'b1;
        tick();
        chk("gap_stall", cpu_stall, 0);
        chk("gap_rd", mem_read, 1);
        chk("gap_bg", dma_bg, 0);
        tick();
        chk("rebr_stall", cpu_stall, 1);
        chk("rebr_bg", dma_bg, 0);
        tick();
        chk("rebr_grant", dma_bg, 1);

        // Reset mid-burst returns the port to the CPU
        reset_n = 1'b0;
        tick();
        chk("midrst_bg", dma_bg, 0);
        chk("midrst_stall", cpu_stall, 0);
        chk("midrst_cycles", dma_cycles, 0);
        dma_br = 1'b0;
        reset_n = 1'b1;
        tick();
        chk("postrst_stall", cpu_stall, 0);
        chk("postrst_rd", mem_read, 1);
        chk("postrst_bg", dma_bg, 0);

        // Stray DMA write without grant: suppressed, sticky error until reset
        cpu_req = 1'b0; dma_write = 1'b1; dma_addr = 16'h0BAD;
        #1;
        chk("stray_wr", mem_write, 0);
        chk("stray_err_pre", bus_err, 0);
        tick();
        chk("stray_err", bus_err, 1);
        dma_write = 1'b0;
        tick(); tick();
        chk("stray_sticky", bus_err, 1);
        chk("stray_cycles", dma_cycles, 0);
        reset_n = 1'b0;
        tick();
        chk("stray_clr", bus_err, 0);
        reset_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no end expected end of stimulus");
        $fatal(1, "timeout");
    end

endmodule
